axil_mitm_rd: RTL and testbench

AXI4-lite read broadcaster: accepts one read on the slave port and issues it to all M_COUNT master ports in parallel. It collects one R beat from every master and returns a single response upstream, with data from master 0 and the worst-case response code. It is the read-channel companion of the AXI4-lite write man-in-the-middle and is placed alongside it on the same interconnect node.

---
 rtl/axil_mitm_rd.sv | 174 +++++++++++++++++
 tb/tb_axil_mitm_rd.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mitm_rd.sv
`default_nettype none
// ============================================================================
// axil_mitm_rd : AXI4-lite read broadcaster, one AR fanned out to M_COUNT
// masters, one merged R back. Optional rdata compare: AXIL_MITM_RD_CMP_EN.
// Revision: 1.0
// ============================================================================
module axil_mitm_rd #(
   parameter int M_COUNT    = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_WIDTH-1:0]         s_axil_araddr,
   input  logic [2:0]                    s_axil_arprot,
   input  logic                          s_axil_arvalid,
   output logic                          s_axil_arready,
   output logic [DATA_WIDTH-1:0]         s_axil_rdata,
   output logic [1:0]                    s_axil_rresp,
   output logic                          s_axil_rvalid,
   input  logic                          s_axil_rready,
   output logic [M_COUNT*ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [M_COUNT*3-1:0]          m_axil_arprot,
   output logic [M_COUNT-1:0]            m_axil_arvalid,
   input  logic [M_COUNT-1:0]            m_axil_arready,
   input  logic [M_COUNT*DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [M_COUNT*2-1:0]          m_axil_rresp,
   input  logic [M_COUNT-1:0]            m_axil_rvalid,
   output logic [M_COUNT-1:0]            m_axil_rready,
   output logic                          mismatch
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_COLLECT = 3'b010,
      ST_RESP    = 3'b100
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   araddr_q;
   logic [2:0]              arprot_q;
   logic [M_COUNT-1:0]      arvalid_q;
   logic [M_COUNT-1:0]      rready_q;
   logic [M_COUNT-1:0]      done_q;
   logic [DATA_WIDTH-1:0]   cap_data_q [M_COUNT];
   logic [1:0]              cap_resp_q [M_COUNT];
   logic                    s_arready_q;
   logic                    s_rvalid_q;
   logic [DATA_WIDTH-1:0]   s_rdata_q;
   logic [1:0]              s_rresp_q;
   logic                    mismatch_q;

   logic [M_COUNT-1:0]      r_hs;
   logic [M_COUNT-1:0]      done_d;
   logic [M_COUNT-1:0]      arvalid_d;
   logic [DATA_WIDTH-1:0]   eff_data [M_COUNT];
   logic [1:0]              eff_resp [M_COUNT];
   logic [1:0]              worst_resp;
   logic [1:0]              final_resp;
   logic                    data_diff;

   assign r_hs      = m_axil_rvalid & rready_q;
   assign done_d    = done_q | r_hs;
   assign arvalid_d = arvalid_q & ~m_axil_arready;

   // Beats landing this cycle are folded in so completion needs no extra cycle.
   generate
      for (genvar i = 0; i < M_COUNT; i++) begin : g_eff
         assign eff_data[i] = r_hs[i] ? m_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH] : cap_data_q[i];
         assign eff_resp[i] = r_hs[i] ? m_axil_rresp[i*2 +: 2] : cap_resp_q[i];
      end
   endgenerate

   always_comb begin
      worst_resp = 2'b00;
      for (int i = 0; i < M_COUNT; i++) begin
         if (eff_resp[i] > worst_resp) worst_resp = eff_resp[i];
      end
   end

`ifdef AXIL_MITM_RD_CMP_EN
   always_comb begin
      data_diff = 1'b0;
      for (int i = 1; i < M_COUNT; i++) begin
         if (eff_data[i] != eff_data[0]) data_diff = 1'b1;
      end
   end
   // DECERR outranks the SLVERR raised by a data disagreement.
   assign final_resp = (data_diff && (worst_resp != 2'b11)) ? 2'b10 : worst_resp;
`else
   logic unused_data;
   always_comb begin
      unused_data = 1'b0;
      for (int i = 0; i < M_COUNT; i++) unused_data = unused_data ^ (^eff_data[i]);
   end
   assign data_diff  = 1'b0;
   assign final_resp = worst_resp;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         araddr_q    <= '0;
         arprot_q    <= '0;
         arvalid_q   <= '0;
         rready_q    <= '0;
         done_q      <= '0;
         s_arready_q <= 1'b0;
         s_rvalid_q  <= 1'b0;
         s_rdata_q   <= '0;
         s_rresp_q   <= '0;
         mismatch_q  <= 1'b0;
         for (int i = 0; i < M_COUNT; i++) begin
            cap_data_q[i] <= '0;
            cap_resp_q[i] <= '0;
         end
      end else begin
         arvalid_q  <= arvalid_d;
         mismatch_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               s_arready_q <= ~|arvalid_d;
               if (s_arready_q && s_axil_arvalid) begin
                  araddr_q    <= s_axil_araddr;
                  arprot_q    <= s_axil_arprot;
                  arvalid_q   <= '1;
                  rready_q    <= '1;
                  done_q      <= '0;
                  s_arready_q <= 1'b0;
                  state_q     <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               rready_q <= rready_q & ~r_hs;
               done_q   <= done_d;
               for (int i = 0; i < M_COUNT; i++) begin
                  if (r_hs[i]) begin
                     cap_data_q[i] <= eff_data[i];
                     cap_resp_q[i] <= eff_resp[i];
                  end
               end
               if (&done_d) begin
                  s_rdata_q  <= eff_data[0];
                  s_rresp_q  <= final_resp;
                  s_rvalid_q <= 1'b1;
                  mismatch_q <= data_diff;
                  rready_q   <= '0;
                  state_q    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (s_axil_rready) begin
                  s_rvalid_q  <= 1'b0;
                  s_arready_q <= ~|arvalid_d;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_axil_arready = s_arready_q;
   assign s_axil_rdata   = s_rdata_q;
   assign s_axil_rresp   = s_rresp_q;
   assign s_axil_rvalid  = s_rvalid_q;
   assign m_axil_araddr  = {M_COUNT{araddr_q}};
   assign m_axil_arprot  = {M_COUNT{arprot_q}};
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = rready_q;
   assign mismatch       = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_mitm_rd.sv
`default_nettype none
// ============================================================================
// tb_axil_mitm_rd : table-driven bench with a two-master downstream model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axil_mitm_rd;
   localparam int M  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef AXIL_MITM_RD_CMP_EN
   localparam bit CMP = 1'b1;
`else
   localparam bit CMP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   s_axil_araddr;
   logic [2:0]      s_axil_arprot;
   logic            s_axil_arvalid;
   logic            s_axil_arready;
   logic [DW-1:0]   s_axil_rdata;
   logic [1:0]      s_axil_rresp;
   logic            s_axil_rvalid;
   logic            s_axil_rready;
   logic [M*AW-1:0] m_axil_araddr;
   logic [M*3-1:0]  m_axil_arprot;
   logic [M-1:0]    m_axil_arvalid;
   logic [M-1:0]    m_axil_arready;
   logic [M*DW-1:0] m_axil_rdata;
   logic [M*2-1:0]  m_axil_rresp;
   logic [M-1:0]    m_axil_rvalid;
   logic [M-1:0]    m_axil_rready;
   logic            mismatch;

   always #5 clk = ~clk;

   axil_mitm_rd #(.M_COUNT(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
      .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
      .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
      .mismatch(mismatch)
   );

   typedef struct {
      int          ard0, ard1, rd0, rd1;
      logic [31:0] addr;
      logic [2:0]  prot;
      logic [31:0] d0, d1;
      logic [1:0]  r0, r1;
      int          hold;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      int          exp_mm;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
      int          mm;
      int          lat;
   } exp_t;

   vec_t        vecs [7];
   exp_t        sb [$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          ph [M];
   int          cnt [M];
   int          cur_ard [M];
   int          cur_rd [M];
   logic [31:0] cur_d [M];
   logic [1:0]  cur_r [M];
   bit          model_en = 1'b1;
   bit          seen = 1'b1;
   int          rr_err, mm_cnt, last_hs, ar_cyc;
   logic [31:0] held_d;
   logic [1:0]  held_r;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (mismatch === 1'b1) mm_cnt++;
      if (s_axil_rvalid === 1'b1 && !seen) begin
         seen   = 1'b1;
         held_d = s_axil_rdata;
         held_r = s_axil_rresp;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=rvalid required=no_response (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("rdata", s_axil_rdata, e.d);
            chk("rresp", s_axil_rresp, e.r);
            chk("mismatch_at_rise", mismatch, e.mm);
            chk("latency", cyc - ar_cyc, e.lat);
            chk("after_last_beat", cyc, last_hs + 1);
         end
      end
   endtask

   // Downstream masters: arready after ard cycles, one R beat rd cycles later.
   task automatic model();
      for (int i = 0; i < M; i++) begin
         m_axil_arready[i] = 1'b0;
         if (!model_en) begin
            m_axil_rvalid[i] = 1'b0;
         end else begin
            case (ph[i])
               0: if (m_axil_arvalid[i]) begin
                     if (cnt[i] == cur_ard[i]) begin
                        m_axil_arready[i] = 1'b1;
                        ph[i]  = 1;
                        cnt[i] = 0;
                     end else cnt[i]++;
                  end
               1: if (cnt[i] == cur_rd[i]) begin
                     m_axil_rvalid[i]          = 1'b1;
                     m_axil_rdata[i*DW +: DW]  = cur_d[i];
                     m_axil_rresp[i*2 +: 2]    = cur_r[i];
                     if (m_axil_rready[i]) begin
                        ph[i]   = 3;
                        last_hs = cyc;
                     end else ph[i] = 2;
                  end else cnt[i]++;
               2: if (m_axil_rready[i]) begin
                     ph[i]   = 3;
                     last_hs = cyc;
                  end
               default: begin
                  m_axil_rvalid[i] = 1'b0;
                  if (m_axil_rready[i]) rr_err++;
                  ph[i] = 4;
               end
            endcase
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      monitor();
      model();
   endtask

   task automatic setup(input vec_t v);
      cur_ard[0] = v.ard0; cur_ard[1] = v.ard1;
      cur_rd[0]  = v.rd0;  cur_rd[1]  = v.rd1;
      cur_d[0]   = v.d0;   cur_d[1]   = v.d1;
      cur_r[0]   = v.r0;   cur_r[1]   = v.r1;
      for (int i = 0; i < M; i++) begin
         ph[i]  = 0;
         cnt[i] = 0;
      end
      rr_err  = 0;
      mm_cnt  = 0;
      seen    = 1'b0;
      last_hs = -100;
   endtask

   task automatic issue_ar(input vec_t v);
      exp_t e;
      int   n;
      n = 0;
      while (s_axil_arready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("arready_idle", s_axil_arready, 1'b1);
      s_axil_araddr  = v.addr;
      s_axil_arprot  = v.prot;
      s_axil_arvalid = 1'b1;
      ar_cyc = cyc;
      e.d = v.exp_data; e.r = v.exp_resp; e.mm = v.exp_mm; e.lat = v.exp_lat;
      sb.push_back(e);
      step();
      s_axil_arvalid = 1'b0;
      chk("m_arvalid", m_axil_arvalid, 2'b11);
      chk("m_rready", m_axil_rready, 2'b11);
      chk("m_araddr", m_axil_araddr, {v.addr, v.addr});
      chk("m_arprot", m_axil_arprot, {v.prot, v.prot});
      chk("arready_busy", s_axil_arready, 1'b0);
   endtask

   task automatic run(input vec_t v);
      int n;
      int stab_err;
      setup(v);
      issue_ar(v);
      n = 0;
      while (!seen && n < 60) begin
         step();
         n++;
      end
      chk("rvalid_seen", seen, 1'b1);
      stab_err = 0;
      for (int h = 0; h < v.hold; h++) begin
         step();
         if (!(s_axil_rvalid === 1'b1 && s_axil_rdata === held_d && s_axil_rresp === held_r))
            stab_err++;
      end
      chk("hold_stable", stab_err, 0);
      s_axil_rready = 1'b1;
      step();
      s_axil_rready = 1'b0;
      chk("arready_after_r", s_axil_arready, 1'b1);
      chk("rvalid_cleared", s_axil_rvalid, 1'b0);
      chk("mismatch_pulses", mm_cnt, v.exp_mm);
      chk("rready_after_capture", rr_err, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_arready"}, s_axil_arready, 1'b0);
      chk({tag, "_rvalid"}, s_axil_rvalid, 1'b0);
      chk({tag, "_rdata"}, s_axil_rdata, '0);
      chk({tag, "_rresp"}, s_axil_rresp, '0);
      chk({tag, "_m_arvalid"}, m_axil_arvalid, '0);
      chk({tag, "_m_rready"}, m_axil_rready, '0);
      chk({tag, "_m_araddr"}, m_axil_araddr, '0);
      chk({tag, "_m_arprot"}, m_axil_arprot, '0);
      chk({tag, "_mismatch"}, mismatch, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t rv;
      //           ard0 ard1 rd0 rd1 addr          prot    d0            d1            r0 r1 hold exp_data      exp_resp            mm            lat
      vecs[0] = '{0, 0, 0, 0, 32'h1000_0000, 3'b000, 32'h1234_5678, 32'h1234_5678, 2'd0, 2'd0, 0, 32'h1234_5678, 2'd0, 0, 3};
      vecs[1] = '{0, 4, 0, 0, 32'h1000_0004, 3'b001, 32'h1111_1111, 32'h1111_1111, 2'd0, 2'd0, 0, 32'h1111_1111, 2'd0, 0, 7};
      vecs[2] = '{1, 0, 0, 2, 32'h2000_0008, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd0, 2'd3, 1, 32'hDEAD_BEEF, 2'd3, 0, 5};
      vecs[3] = '{0, 0, 1, 0, 32'h3000_000C, 3'b100, 32'hAAAA_0000, 32'hAAAA_0001, 2'd0, 2'd0, 0, 32'hAAAA_0000,
                  CMP ? 2'd2 : 2'd0, CMP ? 1 : 0, 4};
      vecs[4] = '{0, 0, 0, 0, 32'h4000_0010, 3'b111, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 2'd1, 2'd0, 6, 32'h5A5A_5A5A, 2'd1, 0, 3};
      vecs[5] = '{2, 1, 0, 3, 32'h5000_0014, 3'b011, 32'h0000_0000, 32'hFFFF_FFFF, 2'd3, 2'd0, 2, 32'h0000_0000,
                  2'd3, CMP ? 1 : 0, 7};
      vecs[6] = '{0, 0, 0, 0, 32'h6000_0018, 3'b101, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'd2, 2'd1, 0, 32'hCAFE_F00D, 2'd2, 0, 3};

      rst            = 1'b1;
      s_axil_araddr  = '0;
      s_axil_arprot  = '0;
      s_axil_arvalid = 1'b0;
      s_axil_rready  = 1'b0;
      m_axil_arready = '0;
      m_axil_rdata   = '0;
      m_axil_rresp   = '0;
      m_axil_rvalid  = '0;
      for (int i = 0; i < M; i++) begin
         ph[i] = 4;
         cnt[i] = 0;
      end
      rr_err = 0;
      repeat (3) step();
      check_reset_outputs("por");
      rst = 1'b0;
      step();
      chk("arready_after_por", s_axil_arready, 1'b1);

      for (int k = 0; k < 7; k++) run(vecs[k]);

      // Reset in the middle of COLLECT: master 0 captured, master 1 still pending.
      rv = vecs[1];
      rv.ard1 = 8;
      setup(rv);
      issue_ar(rv);
      repeat (3) step();
      chk("collect_m_rready", m_axil_rready, 2'b10);
      model_en       = 1'b0;
      m_axil_arready = '0;
      m_axil_rvalid  = '0;
      rst            = 1'b1;
      step();
      check_reset_outputs("mid_rst");
      sb.delete();
      seen = 1'b1;
      rst  = 1'b0;
      step();
      chk("arready_after_mid_rst", s_axil_arready, 1'b1);
      model_en = 1'b1;
      run(vecs[3]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
